// File: rtl/easyaxi_pkg.sv
// Shared AXI constants, pattern seed and state encoding for the EasyAXI traffic generator.
package easyaxi_pkg;

    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [31:0] TG_PATTERN     = 32'hA5A5A5A5;

    typedef enum logic [2:0] {
        TG_IDLE    = 3'd0,
        TG_WR_ADDR = 3'd1,
        TG_WR_DATA = 3'd2,
        TG_WR_RESP = 3'd3,
        TG_RD_ADDR = 3'd4,
        TG_RD_DATA = 3'd5,
        TG_DONE    = 3'd6
    } tg_state_t;

endpackage

// File: rtl/easyaxi_tg_watchdog.sv
// Handshake-idle watchdog: counts active cycles without any channel handshake and flags expiry
// on the TIMEOUT_CYC-th such cycle.
module easyaxi_tg_watchdog #(
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    input  logic i_handshake,
    output logic o_expire
);

    localparam int            CW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_count;

    assign o_expire = i_active && !i_handshake && (r_count == LIMIT);

    // idle counter: restarts on any handshake, outside the active states, and after expiry
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (!i_active || i_handshake || o_expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/easyaxi_traffic_gen.sv
// AXI master traffic generator: writes TXN_NUM INCR bursts of an address-derived pattern,
// reads them back, checks every beat and reports sticky error/timeout status with done.
module easyaxi_traffic_gen
    import easyaxi_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    TXN_NUM     = 8,
    parameter int                    BURST_LEN   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    TIMEOUT_CYC = 10000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  done,
    output logic                  error,
    output logic                  timeout,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast
);

    localparam int               BEAT_BYTES  = DATA_WIDTH / 8;
    localparam int               BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int               TXN_W       = $clog2(TXN_NUM + 1);
    localparam logic [TXN_W-1:0] LAST_TXN    = TXN_W'(TXN_NUM - 1);
    localparam logic [7:0]       LAST_BEAT   = 8'(BURST_LEN - 1);

    if (BURST_BYTES > 4096) begin : g_chk_4k
        $error("easyaxi_traffic_gen: burst crosses a 4KB boundary");
    end
    if ((BASE_ADDR % BURST_BYTES) != 0) begin : g_chk_align
        $error("easyaxi_traffic_gen: BASE_ADDR not aligned to burst size");
    end

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [7:0] beat);
        return base + ADDR_WIDTH'(beat) * ADDR_WIDTH'(BEAT_BYTES);
    endfunction

    // pattern word is replicated bitwise across the data bus, truncating the top copy
    function automatic logic [DATA_WIDTH-1:0] beat_pattern(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] v;
        logic [DATA_WIDTH-1:0] d;
        v = a ^ ADDR_WIDTH'(TG_PATTERN);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            d[i] = v[i % ADDR_WIDTH];
        end
        return d;
    endfunction

    tg_state_t        r_state;
    tg_state_t        w_next_state;
    logic [TXN_W-1:0] r_txn;
    logic [7:0]       r_beat;
    logic             w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic             w_any_hs, w_active, w_expire, w_last_beat, w_last_txn;

    assign w_aw_hs     = awvalid && awready;
    assign w_w_hs      = wvalid && wready;
    assign w_b_hs      = bvalid && bready;
    assign w_ar_hs     = arvalid && arready;
    assign w_r_hs      = rvalid && rready;
    assign w_any_hs    = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;
    assign w_active    = (r_state != TG_IDLE) && (r_state != TG_DONE);
    assign w_last_beat = (r_beat == LAST_BEAT);
    assign w_last_txn  = (r_txn == LAST_TXN);

    easyaxi_tg_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_active    (w_active),
        .i_handshake (w_any_hs),
        .o_expire    (w_expire)
    );

    // next-state logic; watchdog expiry overrides every other transition
    always_comb begin
        w_next_state = r_state;
        if (w_expire) begin
            w_next_state = TG_DONE;
        end else begin
            case (r_state)
                TG_IDLE:    w_next_state = enable ? TG_WR_ADDR : TG_IDLE;
                TG_WR_ADDR: w_next_state = w_aw_hs ? TG_WR_DATA : TG_WR_ADDR;
                TG_WR_DATA: w_next_state = (w_w_hs && wlast) ? TG_WR_RESP : TG_WR_DATA;
                TG_WR_RESP: w_next_state = !w_b_hs ? TG_WR_RESP :
                                           (w_last_txn ? TG_RD_ADDR : TG_WR_ADDR);
                TG_RD_ADDR: w_next_state = w_ar_hs ? TG_RD_DATA : TG_RD_ADDR;
                TG_RD_DATA: w_next_state = !(w_r_hs && w_last_beat) ? TG_RD_DATA :
                                           (w_last_txn ? TG_DONE : TG_RD_ADDR);
                TG_DONE:    w_next_state = enable ? TG_DONE : TG_IDLE;
                default:    w_next_state = TG_IDLE;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TG_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // registered channel controls, payloads, counters and sticky status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            timeout <= 1'b0;
            awaddr  <= '0;
            awlen   <= 8'd0;
            araddr  <= '0;
            arlen   <= 8'd0;
            wdata   <= '0;
            wlast   <= 1'b0;
            r_txn   <= '0;
            r_beat  <= 8'd0;
        end else begin
            awvalid <= (w_next_state == TG_WR_ADDR);
            wvalid  <= (w_next_state == TG_WR_DATA);
            bready  <= (w_next_state == TG_WR_RESP);
            arvalid <= (w_next_state == TG_RD_ADDR);
            rready  <= (w_next_state == TG_RD_DATA);
            done    <= (w_next_state == TG_DONE);
            if (w_expire) begin
                timeout <= 1'b1;
            end
            case (r_state)
                TG_IDLE: begin
                    if (enable) begin
                        r_txn   <= '0;
                        r_beat  <= 8'd0;
                        error   <= 1'b0;
                        timeout <= 1'b0;
                        awaddr  <= BASE_ADDR;
                        awlen   <= LAST_BEAT;
                        arlen   <= LAST_BEAT;
                    end
                end
                TG_WR_ADDR: begin
                    if (w_aw_hs) begin
                        r_beat <= 8'd0;
                        wdata  <= beat_pattern(awaddr);
                        wlast  <= (LAST_BEAT == 8'd0);
                    end
                end
                TG_WR_DATA: begin
                    if (w_w_hs && !wlast) begin
                        r_beat <= r_beat + 8'd1;
                        wdata  <= beat_pattern(beat_addr(awaddr, r_beat + 8'd1));
                        wlast  <= ((r_beat + 8'd1) == LAST_BEAT);
                    end
                end
                TG_WR_RESP: begin
                    if (w_b_hs) begin
                        if (bresp != AXI_RESP_OKAY) begin
                            error <= 1'b1;
                        end
                        if (w_last_txn) begin
                            r_txn  <= '0;
                            araddr <= BASE_ADDR;
                        end else begin
                            r_txn  <= r_txn + TXN_W'(1);
                            awaddr <= awaddr + ADDR_WIDTH'(BURST_BYTES);
                        end
                    end
                end
                TG_RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_beat <= 8'd0;
                    end
                end
                TG_RD_DATA: begin
                    if (w_r_hs) begin
                        if ((rresp != AXI_RESP_OKAY) || (rlast != w_last_beat) ||
                            (rdata != beat_pattern(beat_addr(araddr, r_beat)))) begin
                            error <= 1'b1;
                        end
                        r_beat <= r_beat + 8'd1;
                        if (w_last_beat && !w_last_txn) begin
                            r_txn  <= r_txn + TXN_W'(1);
                            araddr <= araddr + ADDR_WIDTH'(BURST_BYTES);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_easyaxi_traffic_gen.sv
// Bench for easyaxi_traffic_gen: behavioural memory slave with configurable faults and
// backpressure, plus a table of scenarios with expected final status.
module tb_easyaxi_traffic_gen;

    localparam int          BL   = 4;
    localparam int          TXN  = 2;
    localparam int          TO   = 100;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        done, error, timeout;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    easyaxi_traffic_gen #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .TXN_NUM (TXN), .BURST_LEN (BL),
        .BASE_ADDR (BASE), .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk), .rst (rst), .enable (enable), .done (done), .error (error), .timeout (timeout),
        .awvalid (awvalid), .awready (awready), .awaddr (awaddr), .awlen (awlen),
        .wvalid (wvalid), .wready (wready), .wdata (wdata), .wlast (wlast),
        .bvalid (bvalid), .bready (bready), .bresp (bresp),
        .arvalid (arvalid), .arready (arready), .araddr (araddr), .arlen (arlen),
        .rvalid (rvalid), .rready (rready), .rdata (rdata), .rresp (rresp), .rlast (rlast)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference rules: burst i starts at BASE + i*burst bytes; beat data = byte address ^ A5A5A5A5
    function automatic logic [31:0] exp_addr(input int i);
        return BASE + 32'(i * BL * 4);
    endfunction
    function automatic logic [31:0] exp_data(input logic [31:0] a);
        return a ^ 32'hA5A5A5A5;
    endfunction

    typedef struct {
        bit bp; bit gaps; bit flip; bit bad_b; bit never_ar;
        bit exp_err; bit exp_to; int exp_aw; int exp_ar;
    } vec_t;

    bit m_bp, m_gaps, m_flip, m_bad_b, m_never_ar;
    int aw_cnt, w_cnt, ar_cnt, r_cnt, s_wbursts;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] s_waddr, s_raddr, p_awaddr, p_wdata, p_araddr;
    logic        p_wlast;
    int  s_wbeat, s_rbeat;
    bit  s_bpend, s_ractive, hs_b, hs_r, st_aw, st_w, st_ar;

    // memory slave and channel monitor; handshakes are decided here for the next rising edge
    always @(negedge clk) begin
        if (rst) begin
            awready = 1'b0; wready = 1'b0; arready = 1'b0;
            bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0;
            s_bpend = 1'b0; s_ractive = 1'b0; hs_b = 1'b0; hs_r = 1'b0;
            st_aw = 1'b0; st_w = 1'b0; st_ar = 1'b0; s_wbeat = 0; s_rbeat = 0;
        end else begin
            if (!timeout) begin
                if (st_aw) check("aw_hold", 64'({awvalid, awaddr, awlen}), 64'({1'b1, p_awaddr, 8'd3}));
                if (st_w)  check("w_hold", 64'({wvalid, wlast, wdata}), 64'({1'b1, p_wlast, p_wdata}));
                if (st_ar) check("ar_hold", 64'({arvalid, araddr, arlen}), 64'({1'b1, p_araddr, 8'd3}));
            end
            if (hs_b) begin bvalid = 1'b0; hs_b = 1'b0; end
            if (hs_r) begin
                rvalid = 1'b0; rlast = 1'b0; hs_r = 1'b0; s_rbeat++;
                if (s_rbeat == BL) s_ractive = 1'b0;
            end
            if (s_bpend && !bvalid) begin
                bvalid = 1'b1;
                bresp  = (m_bad_b && s_wbursts == 1) ? 2'b10 : 2'b00;
            end
            if (s_ractive && !rvalid && (!m_gaps || $urandom_range(0, 2) != 0)) begin
                rvalid = 1'b1;
                rdata  = mem[s_raddr + 32'(4 * s_rbeat)];
                if (m_flip && ar_cnt == 2 && s_rbeat == 2) rdata[0] = ~rdata[0];
                rresp  = 2'b00;
                rlast  = (s_rbeat == BL - 1);
            end
            awready = m_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = m_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            arready = m_never_ar ? 1'b0 : (m_bp ? 1'($urandom_range(0, 1)) : 1'b1);

            if (awvalid && awready) begin
                check("awaddr", 64'(awaddr), 64'(exp_addr(aw_cnt)));
                check("awlen", 64'(awlen), 64'(8'd3));
                s_waddr = awaddr; s_wbeat = 0; aw_cnt++;
            end
            if (wvalid && wready) begin
                check("wdata", 64'(wdata), 64'(exp_data(exp_addr(aw_cnt - 1) + 32'(4 * s_wbeat))));
                check("wlast", 64'(wlast), 64'(s_wbeat == BL - 1));
                mem[s_waddr + 32'(4 * s_wbeat)] = wdata;
                s_wbeat++; w_cnt++;
                if (wlast) begin s_bpend = 1'b1; s_wbursts++; end
            end
            if (bvalid && bready) begin hs_b = 1'b1; s_bpend = 1'b0; end
            if (arvalid && arready) begin
                check("araddr", 64'(araddr), 64'(exp_addr(ar_cnt)));
                check("arlen", 64'(arlen), 64'(8'd3));
                s_raddr = araddr; s_rbeat = 0; s_ractive = 1'b1; ar_cnt++;
            end
            if (rvalid && rready) begin hs_r = 1'b1; r_cnt++; end

            st_aw = awvalid && !awready; p_awaddr = awaddr;
            st_w  = wvalid && !wready;   p_wdata = wdata; p_wlast = wlast;
            st_ar = arvalid && !arready; p_araddr = araddr;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({awvalid, wvalid, bready, arvalid, rready, done, error, timeout, wlast}), 64'(0));
        check({tag, "_len"}, 64'({awlen, arlen}), 64'(0));
        check({tag, "_addr"}, 64'({awaddr, araddr}), 64'(0));
        check({tag, "_wdata"}, 64'(wdata), 64'(0));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  t_ar, t_done;
        bit  seen_ar;
        string tg;
        tg = $sformatf("v%0d", idx);
        m_bp = v.bp; m_gaps = v.gaps; m_flip = v.flip; m_bad_b = v.bad_b; m_never_ar = v.never_ar;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; s_wbursts = 0;
        mem.delete();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check({tg, "_aw_rise"}, 64'({awvalid, awaddr}), 64'({1'b1, exp_addr(0)}));
        check({tg, "_status_clr"}, 64'({error, timeout, done}), 64'(0));
        seen_ar = 1'b0; t_ar = 0; t_done = -1;
        for (int c = 0; c < 3000; c++) begin
            if (!seen_ar && arvalid) begin seen_ar = 1'b1; t_ar = cyc; end
            if (done) begin t_done = cyc; break; end
            @(negedge clk);
        end
        check({tg, "_done_reached"}, 64'(t_done >= 0), 64'(1));
        check({tg, "_error"}, 64'(error), 64'(v.exp_err));
        check({tg, "_timeout"}, 64'(timeout), 64'(v.exp_to));
        check({tg, "_aw_count"}, 64'(aw_cnt), 64'(v.exp_aw));
        check({tg, "_w_beats"}, 64'(w_cnt), 64'(v.exp_aw * BL));
        check({tg, "_ar_count"}, 64'(ar_cnt), 64'(v.exp_ar));
        check({tg, "_r_beats"}, 64'(r_cnt), 64'(v.exp_ar * BL));
        if (v.never_ar) begin
            check({tg, "_to_latency"}, 64'(t_done - t_ar), 64'(TO));
        end
        repeat (3) @(negedge clk);
        check({tg, "_done_held"}, 64'({done, error, timeout}), 64'({1'b1, v.exp_err, v.exp_to}));
        check({tg, "_idle_chan"}, 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check({tg, "_done_fall"}, 64'(done), 64'(0));
    endtask

    initial begin
        vec_t vecs [6];
        bit   hit;
        //            bp    gaps  flip  bad_b never exp_err exp_to aw ar
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 2};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2};

        m_bp = 1'b0; m_gaps = 1'b0; m_flip = 1'b0; m_bad_b = 1'b0; m_never_ar = 1'b0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; s_wbursts = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #2 rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // reset during the W burst of txn 1, then restart from txn 0
        m_bp = 1'b0; m_gaps = 1'b0; m_flip = 1'b0; m_bad_b = 1'b0; m_never_ar = 1'b0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; s_wbursts = 0;
        @(negedge clk);
        enable = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (aw_cnt == 2 && wvalid) begin hit = 1'b1; break; end
        end
        check("rst_reached_txn1_w", 64'(hit), 64'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        enable = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        run_vec(vecs[0], 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
